// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt vector arbiter: FSM encoding,
// counter width and the vector-number width helper.
package intr_pkg;

  // Width of the saturating request/gap counters.
  localparam int CNT_W = 8;

  // Request FSM encoding.
  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_REQ  = 2'd1,
    STATE_GAP  = 2'd2
  } state_t;

  // Bits needed to encode a port index; never narrower than one bit.
  function automatic int intr_num_w(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage

// File: rtl/intr_vec_arbiter_rr.sv
// Combinational priority arbiter. Fixed mode picks the lowest set index;
// round-robin mode picks the first set index at or above ptr, wrapping to 0.
module rr_priority_arbiter
  import intr_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int ROUND_ROBIN = 0
) (
  input  logic [WIDTH-1:0]             req,
  input  logic [intr_num_w(WIDTH)-1:0] ptr,
  output logic                         valid,
  output logic [intr_num_w(WIDTH)-1:0] idx,
  output logic [WIDTH-1:0]             grant
);

  localparam int IDX_W = intr_num_w(WIDTH);
  localparam logic [WIDTH-1:0] ONE_LSB = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [IDX_W-1:0] idx_lo_s;
  logic [IDX_W-1:0] idx_hi_s;
  logic             hit_hi_s;
  logic             hit_s;

  // Scan from the top down so the lowest qualifying index is the last write.
  always_comb begin
    idx_lo_s = {IDX_W{1'b0}};
    idx_hi_s = {IDX_W{1'b0}};
    hit_hi_s = 1'b0;
    hit_s    = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      idx_lo_s = req[i] ? IDX_W'(i) : idx_lo_s;
      hit_s    = req[i] & (i >= int'(ptr));
      idx_hi_s = hit_s ? IDX_W'(i) : idx_hi_s;
      hit_hi_s = hit_hi_s | hit_s;
    end
  end

  // Select the wrap-aware winner in round-robin mode and form the one-hot grant.
  always_comb begin
    valid = |req;
    if ((ROUND_ROBIN != 0) && hit_hi_s) begin
      idx = idx_hi_s;
    end else begin
      idx = idx_lo_s;
    end
    if (valid) begin
      grant = ONE_LSB << idx;
    end else begin
      grant = {WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/intr_vec_arbiter.sv
// Interrupt vector requester: captures edge/level interrupt sources,
// arbitrates among eligible ports and issues one vector at a time over a
// req/ack handshake with optional ack timeout and inter-request gap.
module intr_vec_arbiter
  import intr_pkg::*;
#(
  parameter int PORTS       = 32,
  parameter int ROUND_ROBIN = 0,
  parameter int INTR_GAP    = 2,
  parameter int ACK_TIMEOUT = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PORTS-1:0]             intr,
  input  logic [PORTS-1:0]             intr_en,
  input  logic [PORTS-1:0]             intr_level,
  input  logic                         intr_vec_ack,
  output logic                         intr_vec_req,
  output logic [intr_num_w(PORTS)-1:0] intr_num,
  output logic [PORTS-1:0]             intr_pending,
  output logic                         intr_timeout
);

  localparam int NUM_W = intr_num_w(PORTS);
  // The IDLE cycle that re-evaluates eligibility is itself a req-low cycle,
  // so GAP only has to cover the remaining INTR_GAP-1 cycles.
  localparam state_t LEAVE_STATE = (INTR_GAP > 1) ? STATE_GAP : STATE_IDLE;
  localparam logic [CNT_W-1:0] GAP_LAST =
      CNT_W'((INTR_GAP > 1) ? (INTR_GAP - 2) : 0);
  localparam logic [CNT_W-1:0] TO_LAST =
      CNT_W'((ACK_TIMEOUT > 0) ? (ACK_TIMEOUT - 1) : 0);
  localparam logic TO_EN = (ACK_TIMEOUT > 0);
  localparam logic [NUM_W-1:0] LAST_PORT = NUM_W'(PORTS - 1);

  state_t           state_r;
  logic             req_r;
  logic [NUM_W-1:0] num_r;
  logic             timeout_r;
  logic [PORTS-1:0] pending_r;
  logic [PORTS-1:0] intr_q_r;
  logic [PORTS-1:0] win_oh_r;
  logic [NUM_W-1:0] ptr_r;
  logic [CNT_W-1:0] cnt_r;

  logic [PORTS-1:0] rise_s;
  logic [PORTS-1:0] clr_s;
  logic [PORTS-1:0] pending_nxt_s;
  logic [PORTS-1:0] eligible_s;
  logic             ack_s;
  logic             to_s;
  logic [NUM_W-1:0] ptr_adv_s;
  logic             arb_valid_s;
  logic [NUM_W-1:0] arb_idx_s;
  logic [PORTS-1:0] arb_grant_s;

  // Edge-detect history; also loads during reset so lines already high are not edges.
  always_ff @(posedge clk) begin
    intr_q_r <= intr;
  end

  // Pending update (new edge beats same-cycle ack clear) and eligibility.
  always_comb begin
    ack_s  = (state_r == STATE_REQ) & intr_vec_ack;
    to_s   = TO_EN & (state_r == STATE_REQ) & ~intr_vec_ack & (cnt_r == TO_LAST);
    rise_s = intr & ~intr_q_r & intr_en & ~intr_level;
    if (ack_s) begin
      clr_s = win_oh_r;
    end else begin
      clr_s = {PORTS{1'b0}};
    end
    pending_nxt_s = ((pending_r & ~clr_s) | rise_s) & ~intr_level;
    eligible_s    = (pending_nxt_s & intr_en) | (intr & intr_level & intr_en);
    if (num_r == LAST_PORT) begin
      ptr_adv_s = {NUM_W{1'b0}};
    end else begin
      ptr_adv_s = num_r + {{(NUM_W-1){1'b0}}, 1'b1};
    end
  end

  rr_priority_arbiter #(
    .WIDTH       (PORTS),
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_arb (
    .req   (eligible_s),
    .ptr   (ptr_r),
    .valid (arb_valid_s),
    .idx   (arb_idx_s),
    .grant (arb_grant_s)
  );

  // Request FSM with registered handshake outputs, pending bits and RR pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= STATE_IDLE;
      req_r     <= 1'b0;
      num_r     <= {NUM_W{1'b0}};
      timeout_r <= 1'b0;
      pending_r <= {PORTS{1'b0}};
      win_oh_r  <= {PORTS{1'b0}};
      ptr_r     <= {NUM_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
    end else begin
      pending_r <= pending_nxt_s;
      timeout_r <= 1'b0;
      case (state_r)
        STATE_IDLE: begin
          if (arb_valid_s) begin
            req_r    <= 1'b1;
            num_r    <= arb_idx_s;
            win_oh_r <= arb_grant_s;
            cnt_r    <= {CNT_W{1'b0}};
            state_r  <= STATE_REQ;
          end
        end
        STATE_REQ: begin
          if (ack_s || to_s) begin
            req_r     <= 1'b0;
            num_r     <= {NUM_W{1'b0}};
            timeout_r <= to_s;
            cnt_r     <= {CNT_W{1'b0}};
            state_r   <= LEAVE_STATE;
            if (ROUND_ROBIN != 0) begin
              ptr_r <= ptr_adv_s;
            end
          end else if (cnt_r != {CNT_W{1'b1}}) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        STATE_GAP: begin
          if (cnt_r == GAP_LAST) begin
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= STATE_IDLE;
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          req_r   <= 1'b0;
          num_r   <= {NUM_W{1'b0}};
          cnt_r   <= {CNT_W{1'b0}};
          state_r <= STATE_IDLE;
        end
      endcase
    end
  end

  assign intr_vec_req = req_r;
  assign intr_num     = num_r;
  assign intr_pending = pending_r;
  assign intr_timeout = timeout_r;

endmodule

// File: tb/tb_intr_vec_arbiter.sv
// Directed self-checking bench for intr_vec_arbiter: fixed priority,
// round-robin and ack-timeout configurations share one set of input lines.
module tb_intr_vec_arbiter;

  localparam int P = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [P-1:0]  intr;
  logic [P-1:0]  en;
  logic [P-1:0]  lvl;
  logic          ack_f, ack_r, ack_t;
  logic          req_f, req_r, req_t;
  logic [4:0]    num_f, num_r, num_t;
  logic [P-1:0]  pend_f, pend_r, pend_t;
  logic          to_f, to_r, to_t;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  intr_vec_arbiter #(.PORTS(P), .ROUND_ROBIN(0), .INTR_GAP(2), .ACK_TIMEOUT(0)) dut_f (
    .clk(clk), .rst(rst), .intr(intr), .intr_en(en), .intr_level(lvl),
    .intr_vec_ack(ack_f), .intr_vec_req(req_f), .intr_num(num_f),
    .intr_pending(pend_f), .intr_timeout(to_f));

  intr_vec_arbiter #(.PORTS(P), .ROUND_ROBIN(1), .INTR_GAP(2), .ACK_TIMEOUT(0)) dut_r (
    .clk(clk), .rst(rst), .intr(intr), .intr_en(en), .intr_level(lvl),
    .intr_vec_ack(ack_r), .intr_vec_req(req_r), .intr_num(num_r),
    .intr_pending(pend_r), .intr_timeout(to_r));

  intr_vec_arbiter #(.PORTS(P), .ROUND_ROBIN(0), .INTR_GAP(2), .ACK_TIMEOUT(4)) dut_t (
    .clk(clk), .rst(rst), .intr(intr), .intr_en(en), .intr_level(lvl),
    .intr_vec_ack(ack_t), .intr_vec_req(req_t), .intr_num(num_t),
    .intr_pending(pend_t), .intr_timeout(to_t));

  // Advance n clock edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Clear all inputs and apply a one-cycle reset.
  task automatic reset_all();
    intr = '0; en = '1; lvl = '0;
    ack_f = 1'b0; ack_r = 1'b0; ack_t = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_all();
    rst = 1'b1;
    tick(1);
    n_cmp++;
    if ({req_f, num_f, pend_f, to_f} !== 39'd0) begin
      n_bad++; $display("FAIL reset_fix: got %0h expected 0", {req_f, num_f, pend_f, to_f});
    end
    n_cmp++;
    if ({req_r, num_r, pend_r, to_r} !== 39'd0) begin
      n_bad++; $display("FAIL reset_rr: got %0h expected 0", {req_r, num_r, pend_r, to_r});
    end
    n_cmp++;
    if ({req_t, num_t, pend_t, to_t} !== 39'd0) begin
      n_bad++; $display("FAIL reset_to: got %0h expected 0", {req_t, num_t, pend_t, to_t});
    end
    rst = 1'b0;
    // Reset in the middle of a request on edge-mode port 0 held high.
    intr[0] = 1'b1;
    tick(1);
    n_cmp++;
    if (req_f !== 1'b1 || num_f !== 5'd0) begin
      n_bad++; $display("FAIL reset_pre_req: req %0b num %0d expected 1/0", req_f, num_f);
    end
    tick(1);
    rst = 1'b1;
    tick(1);
    n_cmp++;
    if (req_f !== 1'b0 || pend_f !== 32'd0) begin
      n_bad++; $display("FAIL reset_mid_req: req %0b pend %0h expected 0/0", req_f, pend_f);
    end
    rst = 1'b0;
    tick(4);
    n_cmp++;
    if (req_f !== 1'b0) begin
      n_bad++; $display("FAIL reset_no_edge: req %0b expected 0", req_f);
    end
    // Same line in level mode requests one cycle after release.
    rst = 1'b1;
    lvl[0] = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    n_cmp++;
    if (req_f !== 1'b1 || num_f !== 5'd0) begin
      n_bad++; $display("FAIL reset_level_req: req %0b num %0d expected 1/0", req_f, num_f);
    end
  endtask

  task automatic test_fixed_priority();
    reset_all();
    intr[5] = 1'b1; intr[2] = 1'b1;
    tick(1);
    intr = '0;
    n_cmp++;
    if (req_f !== 1'b1 || num_f !== 5'd2 || pend_f !== 32'h24) begin
      n_bad++; $display("FAIL fix_first: req %0b num %0d pend %0h expected 1/2/24", req_f, num_f, pend_f);
    end
    tick(2);
    n_cmp++;
    if (req_f !== 1'b1 || num_f !== 5'd2) begin
      n_bad++; $display("FAIL fix_hold: req %0b num %0d expected 1/2", req_f, num_f);
    end
    ack_f = 1'b1;
    tick(1);
    ack_f = 1'b0;
    n_cmp++;
    if (req_f !== 1'b0 || num_f !== 5'd0 || pend_f !== 32'h20) begin
      n_bad++; $display("FAIL fix_ack1: req %0b num %0d pend %0h expected 0/0/20", req_f, num_f, pend_f);
    end
    tick(1);
    n_cmp++;
    if (req_f !== 1'b0) begin
      n_bad++; $display("FAIL fix_gap: req %0b expected 0", req_f);
    end
    tick(1);
    n_cmp++;
    if (req_f !== 1'b1 || num_f !== 5'd5) begin
      n_bad++; $display("FAIL fix_second: req %0b num %0d expected 1/5", req_f, num_f);
    end
    tick(2);
    ack_f = 1'b1;
    tick(1);
    ack_f = 1'b0;
    tick(5);
    n_cmp++;
    if (req_f !== 1'b0 || pend_f !== 32'd0) begin
      n_bad++; $display("FAIL fix_done: req %0b pend %0h expected 0/0", req_f, pend_f);
    end
  endtask

  task automatic test_round_robin();
    int exp_order[6] = '{0, 1, 3, 0, 1, 3};
    int w;
    int low;
    reset_all();
    rst = 1'b1;
    lvl = 32'h0000_000B;
    intr = 32'h0000_000B;
    tick(1);
    rst = 1'b0;
    w = 0;
    while (req_r !== 1'b1 && w < 10) begin
      tick(1);
      w++;
    end
    n_cmp++;
    if (req_r !== 1'b1 || num_r !== 5'(exp_order[0])) begin
      n_bad++; $display("FAIL rr_grant0: req %0b num %0d expected 1/%0d", req_r, num_r, exp_order[0]);
    end
    for (int k = 1; k < 6; k++) begin
      ack_r = 1'b1;
      tick(1);
      ack_r = 1'b0;
      low = 0;
      while (req_r !== 1'b1 && low < 10) begin
        low++;
        tick(1);
      end
      n_cmp++;
      if (low != 2) begin
        n_bad++; $display("FAIL rr_gap%0d: low cycles %0d expected 2", k, low);
      end
      n_cmp++;
      if (req_r !== 1'b1 || num_r !== 5'(exp_order[k])) begin
        n_bad++; $display("FAIL rr_grant%0d: req %0b num %0d expected 1/%0d", k, req_r, num_r, exp_order[k]);
      end
    end
  endtask

  task automatic test_timeout();
    int high;
    int w;
    reset_all();
    intr[7] = 1'b1;
    tick(1);
    intr[7] = 1'b0;
    high = 0;
    while (req_t === 1'b1 && high < 20) begin
      high++;
      tick(1);
    end
    n_cmp++;
    if (high != 4) begin
      n_bad++; $display("FAIL to_req_len: high cycles %0d expected 4", high);
    end
    n_cmp++;
    if (to_t !== 1'b1 || pend_t !== 32'h80) begin
      n_bad++; $display("FAIL to_pulse: timeout %0b pend %0h expected 1/80", to_t, pend_t);
    end
    tick(1);
    n_cmp++;
    if (to_t !== 1'b0) begin
      n_bad++; $display("FAIL to_single: timeout %0b expected 0", to_t);
    end
    w = 0;
    while (req_t !== 1'b1 && w < 10) begin
      tick(1);
      w++;
    end
    n_cmp++;
    if (req_t !== 1'b1 || num_t !== 5'd7) begin
      n_bad++; $display("FAIL to_retry: req %0b num %0d expected 1/7", req_t, num_t);
    end
    ack_t = 1'b1;
    tick(1);
    ack_t = 1'b0;
    n_cmp++;
    if (req_t !== 1'b0 || pend_t !== 32'd0 || to_t !== 1'b0) begin
      n_bad++; $display("FAIL to_ack: req %0b pend %0h timeout %0b expected 0/0/0", req_t, pend_t, to_t);
    end
  endtask

  task automatic test_masking();
    int seen;
    reset_all();
    en[9] = 1'b0;
    intr[9] = 1'b1;
    tick(1);
    n_cmp++;
    if (req_f !== 1'b0 || pend_f !== 32'd0) begin
      n_bad++; $display("FAIL mask_drop: req %0b pend %0h expected 0/0", req_f, pend_f);
    end
    intr[9] = 1'b0;
    tick(2);
    intr[3] = 1'b1;
    tick(1);
    intr[3] = 1'b0;
    n_cmp++;
    if (req_f !== 1'b1 || num_f !== 5'd3) begin
      n_bad++; $display("FAIL mask_busy: req %0b num %0d expected 1/3", req_f, num_f);
    end
    en[9] = 1'b1;
    intr[9] = 1'b1;
    tick(1);
    n_cmp++;
    if (pend_f !== 32'h208) begin
      n_bad++; $display("FAIL mask_capture: pend %0h expected 208", pend_f);
    end
    intr[9] = 1'b0;
    en[9] = 1'b0;
    ack_f = 1'b1;
    tick(1);
    ack_f = 1'b0;
    n_cmp++;
    if (pend_f !== 32'h200) begin
      n_bad++; $display("FAIL mask_retain: pend %0h expected 200", pend_f);
    end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick(1);
      if (req_f === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0 || pend_f !== 32'h200) begin
      n_bad++; $display("FAIL mask_blocked: req cycles %0d pend %0h expected 0/200", seen, pend_f);
    end
    en[9] = 1'b1;
    tick(1);
    n_cmp++;
    if (req_f !== 1'b1 || num_f !== 5'd9) begin
      n_bad++; $display("FAIL mask_reenable: req %0b num %0d expected 1/9", req_f, num_f);
    end
    ack_f = 1'b1;
    tick(1);
    ack_f = 1'b0;
    n_cmp++;
    if (pend_f !== 32'd0) begin
      n_bad++; $display("FAIL mask_clear: pend %0h expected 0", pend_f);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    reset_all();
    intr[4] = 1'b1;
    tick(1);
    n_cmp++;
    if (req_f !== 1'b1 || num_f !== 5'd4 || pend_f !== 32'h10) begin
      n_bad++; $display("FAIL b2b_first: req %0b num %0d pend %0h expected 1/4/10", req_f, num_f, pend_f);
    end
    intr[4] = 1'b0;
    tick(1);
    intr[4] = 1'b1;
    ack_f = 1'b1;
    tick(1);
    ack_f = 1'b0;
    n_cmp++;
    if (req_f !== 1'b0 || pend_f !== 32'h10) begin
      n_bad++; $display("FAIL b2b_edge_wins: req %0b pend %0h expected 0/10", req_f, pend_f);
    end
    w = 0;
    while (req_f !== 1'b1 && w < 10) begin
      tick(1);
      w++;
    end
    n_cmp++;
    if (req_f !== 1'b1 || num_f !== 5'd4) begin
      n_bad++; $display("FAIL b2b_rerequest: req %0b num %0d expected 1/4", req_f, num_f);
    end
    ack_f = 1'b1;
    tick(1);
    ack_f = 1'b0;
    n_cmp++;
    if (pend_f !== 32'd0) begin
      n_bad++; $display("FAIL b2b_clear: pend %0h expected 0", pend_f);
    end
  endtask

  initial begin
    rst = 1'b1;
    intr = '0; en = '1; lvl = '0;
    ack_f = 1'b0; ack_r = 1'b0; ack_t = 1'b0;
    tick(2);
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_timeout();
    test_masking();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
